mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter and transaction sequencer sharing one single-port memory between instruction fetch (IF port) and the ALU's load/store path (D port). Grants one requester at a time and drives a req/ack memory handshake with variable latency. Bounds each access with a timeout watchdog and returns read data or an error pulse to the owning requester. Sits between the fetch/ALU stages and the memory macro.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- TIMEOUT, 16, max BUSY cycles waiting for mem_ack (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid  out  1  fetch response valid (1-cycle pulse)
- if_rdata  out  DATA_W  fetch read data
- if_err  out  1  fetch timed out (qualified by if_rvalid)
- d_req  in  1  load/store request, held until d_gnt
- d_we  in  1  1 = store
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_gnt, d_rvalid, d_rdata, d_err  out  1/1/DATA_W/1  as IF port
- mem_req  out  1  memory request, held until ack/timeout
- mem_we  out  1  memory write enable
- mem_be  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion (1-cycle)
- mem_rdata  in  DATA_W  read data, valid with mem_ack

## Operation
- FSM states: IDLE, BUSY, RESP. Registers: state, owner (IF/D), last_grant, timeout counter, latched rdata, err.
- IDLE: if any req high, pick winner; winner's gnt asserted combinationally this cycle; latch winner's command into mem_* registers; owner ← winner; last_grant ← winner; counter ← 0; → BUSY. No req: stay.
- IF command: mem_we=0, mem_be=all ones, mem_wdata=0. D command: d_we, d_be, d_wdata forwarded unchanged. Addresses forwarded unchanged.
- BUSY: mem_req=1, all mem_* stable. mem_ack: latch mem_rdata (write → latch 0), err←0, → RESP. No ack and counter==TIMEOUT-1: latch rdata 0, err←1, → RESP. Else counter++.
- Ack and timeout threshold in same cycle: ack wins, err=0.
- RESP: owner's rvalid=1, rdata/err driven from latches; other port's rvalid=0; → IDLE.
- gnt never asserted in BUSY/RESP; reqs there are ignored (requester keeps holding).
- mem_ack outside BUSY ignored.
- rdata outputs hold last latched value outside RESP; only meaningful with rvalid.

## Timing
- Reset (async, immediate): state IDLE, all outputs 0 (mem_req drops mid-transaction), counter 0, last_grant=IF, latches 0. Aborted transaction produces no rvalid.
- gnt at cycle T (combinational from req); mem_req high T+1; earliest mem_ack T+1; rvalid T+2.
- Ack in BUSY cycle k (k=0 first) → rvalid at T+2+k.
- Timeout: no ack → mem_req low and rvalid+err at T+1+TIMEOUT.
- Max throughput one transaction per 3 cycles; next gnt earliest cycle after RESP.
- Counter width clog2(TIMEOUT)+1; no wrap.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; on simultaneous if_req and d_req, grant port ≠ last_grant (after reset, D wins first tie). Single requester always granted.
- Undefined: fixed priority, D always wins ties; last_grant still updated but unused for arbitration.

## Test plan
- Reset, idle: all outputs 0; if_req=1, if_addr=0x100, mem_ack 2 cycles after mem_req rises with mem_rdata=0xDEADBEEF → if_gnt at T, mem_req T+1..T+3, if_rvalid at T+4 with if_rdata=0xDEADBEEF, if_err=0.
- Store: d_we=1, d_be=0x3, d_addr=0x204, d_wdata=0x1234 → mem_we=1, mem_be=0x3, mem_addr=0x204, mem_wdata=0x1234; ack → d_rvalid, d_rdata=0.
- Tie, both reqs held 4 transactions: RR_EN → grant order D,IF,D,IF; undefined → D,D,D,D while d_req held.
- Timeout: TIMEOUT=16, never ack → mem_req high exactly 16 cycles, then d_rvalid=1, d_err=1, d_rdata=0; late mem_ack next cycle ignored.
- Ack on final BUSY cycle (counter=15) → rvalid with err=0, rdata=mem_rdata.
- rst_n low during BUSY → mem_req 0 same cycle, no rvalid afterwards; new if_req after release granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch / load-store) arbiter and sequencer for one single-port memory
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the D port wins ties.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t             state_q, state_d;
   logic               owner_q;       // 1 = D port, 0 = IF port
   logic               last_grant_q;  // same encoding as owner_q
   logic [CNT_W-1:0]   cnt_q;
   logic [DATA_W-1:0]  rdata_q;
   logic               err_q;
   logic               pick_d;
   logic               grant;
   logic               ack_hit;
   logic               to_hit;

`ifdef MEM_ARB_RR_EN
   assign pick_d = d_req && (!if_req || !last_grant_q);
`else
   assign pick_d = d_req;
`endif

   // Gated by rst_n so gnt is also forced low while reset is held.
   assign grant   = (state_q == IDLE) && (if_req || d_req) && rst_n;
   assign if_gnt  = grant && !pick_d;
   assign d_gnt   = grant && pick_d;
   assign ack_hit = (state_q == BUSY) && mem_ack;
   assign to_hit  = (state_q == BUSY) && !mem_ack && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant) state_d = BUSY;
         BUSY:    if (ack_hit || to_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b0;
         cnt_q        <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_be       <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            owner_q      <= pick_d;
            last_grant_q <= pick_d;
            cnt_q        <= '0;
            mem_req      <= 1'b1;
            if (pick_d) begin
               mem_we    <= d_we;
               mem_be    <= d_be;
               mem_addr  <= d_addr;
               mem_wdata <= d_wdata;
            end else begin
               mem_we    <= 1'b0;
               mem_be    <= {BE_W{1'b1}};
               mem_addr  <= if_addr;
               mem_wdata <= '0;
            end
         end else if (ack_hit) begin
            rdata_q <= mem_we ? '0 : mem_rdata;
            err_q   <= 1'b0;
            mem_req <= 1'b0;
         end else if (to_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            mem_req <= 1'b0;
         end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign if_rvalid = (state_q == RESP) && !owner_q;
   assign d_rvalid  = (state_q == RESP) && owner_q;
   assign if_rdata  = rdata_q;
   assign d_rdata   = rdata_q;
   assign if_err    = if_rvalid && err_q;
   assign d_err     = d_rvalid && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, d_req, d_we, mem_ack;
   logic [AW-1:0] if_addr, d_addr;
   logic [3:0]    d_be;
   logic [DW-1:0] d_wdata, mem_rdata;
   logic          if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
   logic [DW-1:0] if_rdata, d_rdata;
   logic          mem_req, mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4*DW+AW+16-1:0] outs;
      rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
      if_addr = '0; d_addr = '0; d_be = '0; d_wdata = '0; mem_rdata = '0;
      step(); step();
      outs = {if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
              mem_req, mem_we, mem_be, mem_addr, mem_wdata, 4'h0};
      total++;
      if (outs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
      rst_n = 1'b1;
      step();
      total++;
      if ({if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid} !== 5'b0) begin
         bad++; $display("FAIL idle_outputs: got %b want 00000", {if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid});
      end
   endtask

   task automatic test_fetch();
      if_req = 1; if_addr = 32'h100;
      #1;
      total++;
      if ({if_gnt, d_gnt} !== 2'b10) begin bad++; $display("FAIL fetch_gnt: got %b want 10", {if_gnt, d_gnt}); end
      step(); if_req = 0;
      total++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0}) begin
         bad++; $display("FAIL fetch_cmd: got %b %b %h %h %h want 1 0 f 100 0", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
      step();
      total++;
      if ({mem_req, if_gnt} !== 2'b10) begin bad++; $display("FAIL fetch_busy: got %b want 10", {mem_req, if_gnt}); end
      step();
      mem_ack = 1; mem_rdata = 32'hDEADBEEF;
      total++;
      if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch_req_t3: got %b want 1", mem_req); end
      step(); mem_ack = 0; mem_rdata = 32'h0;
      total++;
      if ({if_rvalid, if_rdata, if_err, d_rvalid, mem_req} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0}) begin
         bad++; $display("FAIL fetch_resp: got %b %h %b %b %b want 1 deadbeef 0 0 0", if_rvalid, if_rdata, if_err, d_rvalid, mem_req);
      end
      step();
      total++;
      if (if_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_rvalid_drop: got %b want 0", if_rvalid); end
   endtask

   task automatic test_store();
      d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h204; d_wdata = 32'h1234;
      #1;
      total++;
      if ({if_gnt, d_gnt} !== 2'b01) begin bad++; $display("FAIL store_gnt: got %b want 01", {if_gnt, d_gnt}); end
      step(); d_req = 0; d_we = 0;
      total++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h3, 32'h204, 32'h1234}) begin
         bad++; $display("FAIL store_cmd: got %b %b %h %h %h want 1 1 3 204 1234", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
      mem_ack = 1; mem_rdata = 32'hFFFF_0000;
      step(); mem_ack = 0;
      total++;
      if ({d_rvalid, d_rdata, d_err, if_rvalid} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
         bad++; $display("FAIL store_resp: got %b %h %b %b want 1 0 0 0", d_rvalid, d_rdata, d_err, if_rvalid);
      end
      step();
   endtask

   task automatic test_tie();
      logic [3:0] exp_d;
`ifdef MEM_ARB_RR_EN
      exp_d = 4'b0101;
`else
      exp_d = 4'b1111;
`endif
      rst_n = 0; #1; rst_n = 1;
      step();
      if_req = 1; d_req = 1; if_addr = 32'h40; d_addr = 32'h80; d_we = 0; d_be = 4'hF;
      #1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({d_gnt, if_gnt} !== {exp_d[i], ~exp_d[i]}) begin
            bad++; $display("FAIL tie_grant%0d: got d=%b if=%b want d=%b", i, d_gnt, if_gnt, exp_d[i]);
         end
         step();
         total++;
         if ({if_gnt, d_gnt} !== 2'b00) begin bad++; $display("FAIL tie_busy_gnt%0d: got %b want 00", i, {if_gnt, d_gnt}); end
         mem_ack = 1;
         step(); mem_ack = 0;
         total++;
         if ({d_rvalid, if_rvalid, d_gnt, if_gnt} !== {exp_d[i], ~exp_d[i], 2'b00}) begin
            bad++; $display("FAIL tie_resp%0d: got %b want %b", i, {d_rvalid, if_rvalid, d_gnt, if_gnt}, {exp_d[i], ~exp_d[i], 2'b00});
         end
         step();
      end
      if_req = 0; d_req = 0;
      step();
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      int steps = 0;
      mem_rdata = 32'h1111_2222;
      d_req = 1; d_we = 0; d_addr = 32'h300;
      #1;
      total++;
      if (d_gnt !== 1'b1) begin bad++; $display("FAIL to_gnt: got %b want 1", d_gnt); end
      for (int i = 0; i < 40; i++) begin
         step(); d_req = 0; steps++;
         if (d_rvalid) break;
         if (mem_req) req_cycles++;
      end
      total++;
      if (req_cycles !== TO) begin bad++; $display("FAIL to_req_cycles: got %0d want %0d", req_cycles, TO); end
      total++;
      if (steps !== TO + 1) begin bad++; $display("FAIL to_rvalid_cycle: got %0d want %0d", steps, TO + 1); end
      total++;
      if ({d_rvalid, d_err, d_rdata, mem_req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
         bad++; $display("FAIL to_resp: got %b %b %h %b want 1 1 0 0", d_rvalid, d_err, d_rdata, mem_req);
      end
      mem_ack = 1;
      step(); mem_ack = 0;
      step();
      total++;
      if ({d_rvalid, if_rvalid, mem_req} !== 3'b000) begin
         bad++; $display("FAIL to_late_ack: got %b want 000", {d_rvalid, if_rvalid, mem_req});
      end
   endtask

   task automatic test_last_ack();
      if_req = 1; if_addr = 32'h500;
      #1;
      total++;
      if (if_gnt !== 1'b1) begin bad++; $display("FAIL last_gnt: got %b want 1", if_gnt); end
      for (int k = 0; k < TO; k++) step();
      if_req = 0;
      total++;
      if ({mem_req, if_rvalid} !== 2'b10) begin bad++; $display("FAIL last_busy: got %b want 10", {mem_req, if_rvalid}); end
      mem_ack = 1; mem_rdata = 32'hA5A5_5A5A;
      step(); mem_ack = 0;
      total++;
      if ({if_rvalid, if_err, if_rdata} !== {1'b1, 1'b0, 32'hA5A5_5A5A}) begin
         bad++; $display("FAIL last_resp: got %b %b %h want 1 0 a5a55a5a", if_rvalid, if_err, if_rdata);
      end
      step();
   endtask

   task automatic test_reset_busy();
      int seen = 0;
      if_req = 1; if_addr = 32'h600;
      step(); if_req = 0;
      total++;
      if (mem_req !== 1'b1) begin bad++; $display("FAIL rb_busy: got %b want 1", mem_req); end
      rst_n = 0;
      #1;
      total++;
      if (mem_req !== 1'b0) begin bad++; $display("FAIL rb_async_drop: got %b want 0", mem_req); end
      step(); step();
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (if_rvalid || d_rvalid || mem_req) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL rb_no_resp: got %0d want 0", seen); end
      if_req = 1; if_addr = 32'h700;
      #1;
      total++;
      if (if_gnt !== 1'b1) begin bad++; $display("FAIL rb_regrant: got %b want 1", if_gnt); end
      step(); if_req = 0;
      mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
      step(); mem_ack = 0;
      total++;
      if ({if_rvalid, if_rdata, if_err} !== {1'b1, 32'h0BAD_F00D, 1'b0}) begin
         bad++; $display("FAIL rb_resp: got %b %h %b want 1 0badf00d 0", if_rvalid, if_rdata, if_err);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_tie();
      test_timeout();
      test_last_ack();
      test_reset_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200000");
      $fatal(1);
   end
endmodule
